// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the accumulator CPU memory unit and its bench.
// Holds the loader FSM encoding, the debug view, the I/O address and the opcodes.
package mem_unit_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Observation point for checkers: FSM state, loader pointer and CPU activity.
   typedef struct packed {
      state_t     state;
      logic [7:0] ld_ptr;
      logic       rd_active;
      logic       wr_active;
   } dbg_t;

   localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_LD   = 8'h02;
   localparam logic [7:0] OP_ADDI = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h04;
   localparam logic [7:0] OP_ST   = 8'h05;
   localparam logic [7:0] OP_JUMP = 8'h06;

endpackage

// File: rtl/mem_unit_if.sv
// CPU memory bus plus byte-serial loader and output port of the memory unit.
// Loader handshake: a byte transfers on a cycle where ld_valid and ld_ready are both high
// at the rising edge; ld_ready depends only on registered state, never on ld_valid.
interface mem_unit_if;
   logic [7:0] adrs;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       mem_read;
   logic       mem_write;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_last;
   logic       ld_ready;
   logic       cpu_run;
   logic [7:0] out_port;
   logic       out_stb;

   modport master (
      output adrs, wdata, mem_read, mem_write, ld_valid, ld_data, ld_last,
      input  rdata, ld_ready, cpu_run, out_port, out_stb
   );

   modport slave (
      input  adrs, wdata, mem_read, mem_write, ld_valid, ld_data, ld_last,
      output rdata, ld_ready, cpu_run, out_port, out_stb
   );
endinterface

// File: rtl/ram256x8.sv
// 256x8 RAM with a combinational read port and one clocked write port.
// Contents are deliberately not reset so a loaded program survives rst.
module ram256x8 (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [256];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_unit.sv
// Program/data memory, program loader and memory-mapped output port for the CPU.
// Owns cpu_run: the CPU is held until the loader has delivered its last byte.
module mem_unit
   import mem_unit_pkg::*;
#(
   parameter logic [7:0] IO_ADDR = IO_ADDR_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   mem_unit_if.slave bus,
   output dbg_t      dbg
);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ld_ptr;
   logic [7:0] ld_ptr_nxt;
   logic [7:0] out_port_q;
   logic       out_stb_q;

   logic       beat;
   logic       io_hit;
   logic       cpu_wr_io;

   logic       ram_we;
   logic [7:0] ram_waddr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   assign io_hit    = (bus.adrs == IO_ADDR);
   assign cpu_wr_io = (state == RUN) && bus.mem_write && io_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LOAD;
         ld_ptr     <= 8'h00;
         out_port_q <= 8'h00;
         out_stb_q  <= 1'b0;
      end else begin
         state     <= state_nxt;
         ld_ptr    <= ld_ptr_nxt;
         out_stb_q <= cpu_wr_io;
         if (cpu_wr_io) begin
            out_port_q <= bus.wdata;
         end
      end
   end

   // RUN is terminal; only rst returns to LOAD. A beat at 0xFF ends loading since there is no wrap.
   always_comb begin
      state_nxt  = state;
      ld_ptr_nxt = ld_ptr;
      beat       = 1'b0;
      if (state == LOAD) begin
         beat = bus.ld_valid;
         if (beat) begin
            ld_ptr_nxt = ld_ptr + 8'd1;
            if (bus.ld_last || (ld_ptr == 8'hFF)) begin
               state_nxt = RUN;
            end
         end
      end
   end

   // The single write port belongs to the loader in LOAD and to the CPU in RUN.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = bus.adrs;
      ram_wdata = bus.wdata;
      if (state == LOAD) begin
         ram_we    = beat;
         ram_waddr = ld_ptr;
         ram_wdata = bus.ld_data;
      end else begin
         ram_we = bus.mem_write && !io_hit;
      end
   end

   ram256x8 u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (bus.adrs),
      .rdata (ram_rdata)
   );

   assign bus.rdata    = io_hit ? out_port_q : ram_rdata;
   assign bus.ld_ready = (state == LOAD);
   assign bus.cpu_run  = (state == RUN);
   assign bus.out_port = out_port_q;
   assign bus.out_stb  = out_stb_q;

   assign dbg.state     = state;
   assign dbg.ld_ptr    = ld_ptr;
   assign dbg.rd_active = (state == RUN) && bus.mem_read;
   assign dbg.wr_active = (state == RUN) && bus.mem_write;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: acts as program loader and as the CPU's memory bus.
// A reference memory model feeds an expected-value queue that DUT outputs are popped against.
module tb_mem_unit;
   import mem_unit_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_unit_if bus ();
   dbg_t       dbg;

   mem_unit #(.IO_ADDR(IO_ADDR_DEFAULT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .dbg (dbg)
   );

   // scoreboard state
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_mem [256];
   logic       model_run;
   logic [7:0] model_ptr;
   logic [7:0] model_port;
   int         stb_seen = 0;
   int         stb_exp  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [7:0] obs);
      if (exp_q.size() == 0) begin
         check_eq({tag, "_qlen"}, 32'(exp_q.size()), 32'd1);
      end else begin
         check_eq(tag, obs, exp_q.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (rst && bus.out_stb === 1'b1) stb_seen++;
   end

   // driver tasks: each starts and ends 1 time unit after a rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input string tag);
      rst = 1'b0;
      #2;
      check_eq({tag, "_ld_ready"}, bus.ld_ready, 1'b1);
      check_eq({tag, "_cpu_run"},  bus.cpu_run,  1'b0);
      check_eq({tag, "_out_port"}, bus.out_port, 8'h00);
      check_eq({tag, "_out_stb"},  bus.out_stb,  1'b0);
      check_eq({tag, "_ld_ptr"},   dbg.ld_ptr,   8'h00);
      check_eq({tag, "_state"},    dbg.state,    LOAD);
      model_run  = 1'b0;
      model_ptr  = 8'h00;
      model_port = 8'h00;
      step();
      rst = 1'b1;
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      #2;
      check_eq("ld_ready", bus.ld_ready, !model_run);
      step();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      if (!model_run) begin
         model_mem[model_ptr] = d;
         if (last || model_ptr == 8'hFF) model_run = 1'b1;
         model_ptr++;
      end
      check_eq("cpu_run", bus.cpu_run, model_run);
   endtask

   task automatic cpu_read(input logic [7:0] a, input string tag);
      bus.adrs     = a;
      bus.mem_read = 1'b1;
      exp_q.push_back((a == IO_ADDR_DEFAULT) ? model_port : model_mem[a]);
      #2;
      pop_check(tag, bus.rdata);
      step();
      bus.mem_read = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input string tag);
      bus.adrs      = a;
      bus.wdata     = d;
      bus.mem_write = 1'b1;
      step();
      bus.mem_write = 1'b0;
      if (model_run) begin
         if (a == IO_ADDR_DEFAULT) begin
            model_port = d;
            exp_q.push_back(d);
            stb_exp++;
            check_eq({tag, "_stb"}, bus.out_stb, 1'b1);
            pop_check({tag, "_port"}, bus.out_port);
            step();
            check_eq({tag, "_stb_end"}, bus.out_stb, 1'b0);
         end else begin
            model_mem[a] = d;
            check_eq({tag, "_stb_ram"}, bus.out_stb, 1'b0);
         end
      end else begin
         check_eq({tag, "_stb_load"}, bus.out_stb, 1'b0);
      end
   endtask

   task automatic cpu_read_write(input logic [7:0] a, input logic [7:0] d, input string tag);
      bus.adrs      = a;
      bus.wdata     = d;
      bus.mem_read  = 1'b1;
      bus.mem_write = 1'b1;
      exp_q.push_back(model_mem[a]);
      #2;
      pop_check(tag, bus.rdata);
      step();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      model_mem[a]  = d;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.adrs = 8'h00; bus.wdata = 8'h00; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
      model_run = 1'b0; model_ptr = 8'h00; model_port = 8'h00;
      #1;
      reset_dut("rst0");

      // full wrap: 256 bytes without ld_last
      for (int i = 0; i < 256; i++) load_byte(8'(i) ^ 8'h5A, 1'b0);
      check_eq("wrap_state", dbg.state, RUN);
      for (int i = 0; i < 3; i++) load_byte(8'hC3, 1'b1);
      for (int a = 0; a < 255; a++) cpu_read(8'(a), "wrap_rd");
      check_eq("wrap_ram_ff", dut.u_ram.mem[255], model_mem[255]);

      // load then output: LDI 2A ; ST FF
      reset_dut("rst1");
      load_byte(OP_LDI, 1'b0);
      load_byte(8'h2A, 1'b0);
      load_byte(OP_ST, 1'b0);
      load_byte(IO_ADDR_DEFAULT, 1'b1);
      cpu_read(8'h00, "p1_op0");
      cpu_read(8'h01, "p1_arg0");
      cpu_read(8'h02, "p1_op1");
      cpu_read(8'h03, "p1_arg1");
      cpu_write(IO_ADDR_DEFAULT, 8'h2A, "p1_st");
      check_eq("p1_ram_ff", dut.u_ram.mem[255], model_mem[255]);
      cpu_read(IO_ADDR_DEFAULT, "p1_rd_port");
      cpu_read(8'h03, "p1_mem3");

      // loader gating, then CPU write and read-back program
      reset_dut("rst2");
      load_byte(OP_LDI, 1'b0);
      load_byte(8'h11, 1'b0);
      load_byte(OP_ST, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("gap_ptr", dbg.ld_ptr, model_ptr);
         check_eq("gap_ready", bus.ld_ready, 1'b1);
      end
      cpu_write(8'h40, 8'hEE, "gap_wr");
      cpu_write(IO_ADDR_DEFAULT, 8'hEE, "gap_wr_io");
      cpu_read(8'h40, "gap_rd40");
      check_eq("gap_port", bus.out_port, 8'h00);
      check_eq("gap_ptr_end", dbg.ld_ptr, model_ptr);
      load_byte(8'h80, 1'b0);
      load_byte(OP_LD, 1'b0);
      load_byte(8'h80, 1'b0);
      load_byte(OP_ST, 1'b0);
      load_byte(IO_ADDR_DEFAULT, 1'b1);
      cpu_read(8'h00, "p2_rd0");
      cpu_read(8'h01, "p2_rd1");
      cpu_read(8'h02, "p2_rd2");
      cpu_read(8'h03, "p2_rd3");
      cpu_write(8'h80, 8'h11, "p2_st80");
      cpu_read(8'h04, "p2_rd4");
      cpu_read(8'h05, "p2_rd5");
      cpu_read(8'h80, "p2_rd80");
      cpu_read(8'h06, "p2_rd6");
      cpu_read(8'h07, "p2_rd7");
      cpu_write(IO_ADDR_DEFAULT, 8'h11, "p2_stff");
      cpu_read_write(8'h90, 8'h77, "rw_pre");
      cpu_read(8'h90, "rw_post");

      // reset mid-RUN, reload two bytes only
      reset_dut("rst3");
      load_byte(8'hAA, 1'b0);
      load_byte(8'hBB, 1'b1);
      for (int a = 0; a < 8; a++) cpu_read(8'(a), "reload_rd");
      cpu_read(8'h80, "reload_rd80");
      cpu_read(8'h90, "reload_rd90");

      check_eq("stb_count", 32'(stb_seen), 32'(stb_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_unit.md
# mem_unit

Program/data memory and I/O port for the 8-bit accumulator CPU, attached directly to the CPU's memory bus (address, read data, write data, read/write strobes). It provides a 256×8 RAM with same-cycle combinational read and clocked write, matching the CPU's single-cycle memory access. It also provides a byte-serial program loader that fills RAM while the CPU is held inactive, and a memory-mapped output port. It owns the `cpu_run` signal that gates the CPU's reset, so a program is always loaded before execution starts.

## Interface
- `IO_ADDR`, default 8'hFF: address decoded as the output port instead of RAM.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `adrs  in  8`: CPU address; valid while `mem_read` or `mem_write` is high.
- `wdata  in  8`: CPU write data (the CPU's `dout`).
- `rdata  out  8`: read data to the CPU's `din`; combinational.
- `mem_read  in  1`: CPU read strobe; single cycle.
- `mem_write  in  1`: CPU write strobe; single cycle.
- `ld_valid  in  1`: loader byte valid.
- `ld_data  in  8`: loader byte.
- `ld_last  in  1`: qualifies the current `ld_data` as the final byte.
- `ld_ready  out  1`: the unit accepts a loader byte this cycle.
- `cpu_run  out  1`: CPU enable; the CPU's effective reset is `rst & cpu_run`.
- `out_port  out  8`: last value written to `IO_ADDR`.
- `out_stb  out  1`: one-cycle pulse on every write to `IO_ADDR`.

## Operation
- **States**
  - `LOAD` is the reset state.
  - `RUN` is the only other state. There is no path back to `LOAD` except `rst`.
- **LOAD state**
  - `ld_ready`=1 and `cpu_run`=0.
  - A beat is `ld_valid & ld_ready`. On each beat: `mem[ld_ptr] <= ld_data`, then `ld_ptr <= ld_ptr + 1`.
  - A beat with `ld_last`=1 writes its byte and moves to `RUN`.
  - A beat at `ld_ptr`=8'hFF writes its byte and moves to `RUN` even if `ld_last`=0, because RAM is full and there is no wrap.
  - The loader may write address `IO_ADDR`. The byte goes to RAM, not to the port.
  - CPU strobes are ignored in `LOAD`: no RAM write and no `out_stb`. `rdata` still follows `adrs`.
- **RUN state**
  - `ld_ready`=0 and `cpu_run`=1. `ld_valid` is ignored.
  - Read: `rdata = (adrs==IO_ADDR) ? out_port : mem[adrs]`, with no cycle of latency.
  - Write with `adrs!=IO_ADDR`: `mem[adrs] <= wdata`.
  - Write with `adrs==IO_ADDR`: `out_port <= wdata` and `out_stb` is high for the next cycle. RAM at `IO_ADDR` is unchanged.
  - If `mem_read` and `mem_write` are both high, the write takes effect and `rdata` shows the pre-write value.
- **Reset values**
  - State=`LOAD`, `ld_ptr`=0, `ld_ready`=1, `cpu_run`=0, `out_port`=8'h00, `out_stb`=0.
  - RAM is not reset; contents survive `rst`.
  - While both strobes are low, `rdata` = `mem[adrs]` (or `out_port` when `adrs==IO_ADDR`). This value is don't-care.
- **Reset mid-operation**
  - `rst` low during `LOAD` or `RUN` aborts immediately to the reset values. Previously written RAM bytes are retained.

## Timing
- Loader: one byte per cycle maximum. `ld_ready` is a registered function of state only and never depends on `ld_valid`.
- `cpu_run` rises in the cycle after the `ld_last` beat. The CPU's first fetch (`sc`=0) is the cycle after that.
- The RAM write and the `out_port` update are visible on the rising edge that ends the strobe cycle.
- `out_stb` is registered: it is high exactly one cycle, starting the cycle after the write strobe.

## Structure
- Package `mem_unit_pkg`: state enum `{LOAD, RUN}`, the default `IO_ADDR`, and the CPU opcode constants (LDI=01, LD=02, ADDI=03, ADD=04, ST=05, JUMP=06) for shared use by the bench.
- Sub-module `ram256x8`: combinational read port plus one synchronous write port. The write port is muxed between the loader and the CPU by state.
- The top level holds the FSM, `ld_ptr`, the I/O decode and the output register.

## Test plan
- **Reset values:** reset → `ld_ready`=1, `cpu_run`=0, `out_port`=00, `out_stb`=0.
- **Load then output:** load 01 2A 05 FF with `ld_last` on the 4th byte → `cpu_run`=1 one cycle later. After CPU LDI 2A and ST FF: `out_port`=2A and `out_stb` is high for exactly one cycle. RAM[FF] is not written by the ST, and `mem[3]`=FF.
- **Full wrap:** stream 256 bytes with `ld_last`=0 → all 256 are written and the state enters `RUN` after byte 255. Further `ld_valid` has no effect.
- **CPU write and read-back:** program 01 11 05 80 02 80 05 FF → `out_port`=11 and RAM[80]=11.
- **Loader gating:** `ld_valid` held low for several cycles mid-load, and `mem_write` pulsed during `LOAD` → `ld_ptr` holds, RAM is unchanged by the CPU pulse, and `out_stb` stays 0.
- **Reset mid-RUN:** `rst` pulsed low during `RUN` → `cpu_run`=0 and `out_port`=00 immediately. Reloading 2 bytes overwrites `mem[0..1]` only, and the old `mem[2..]` is preserved.
